sccb_cfg_arbiter: RTL
=====================

Name: sccb_cfg_arbiter

Overview:
- Shares one SCCB (I2C-like) register-write master between the two OV7670 camera configuration sequencers (CAM1 dice, CAM2 face).
- Arbitrates requests round-robin and steers the shared master onto the selected camera's sioc/siod pins via cam_sel.
- Sequences each transaction as: setup, start, wait for done, retry on NACK or timeout, then an inter-transaction gap.
- Sits between the per-camera configuration ROM sequencers and the single SCCB master inside the camera system.

Parameters:
- DEV_ID, 8'h42, SCCB write device address driven on m_dev_id.
- SETUP_CYCLES, 4, cycles cam_sel is held stable before m_start.
- GAP_CYCLES, 100, idle cycles after every transaction attempt.
- MAX_RETRY, 3, retries after a failed attempt before reporting error.
- TIMEOUT_CYCLES, 50000, cycles in WAIT without m_done before the attempt counts as failed.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req0  in  1  CAM1 sequencer request; held with addr0/data0 stable until ack0
- addr0  in  8  CAM1 register address
- data0  in  8  CAM1 register data
- ack0  out  1  one-cycle completion pulse to CAM1 sequencer
- err0  out  1  valid with ack0; 1 = failed after all retries
- req1/addr1/data1/ack1/err1  same widths and meanings, for CAM2
- m_start  out  1  one-cycle start pulse to SCCB master
- m_dev_id  out  8  constant DEV_ID
- m_reg_addr  out  8  latched register address
- m_reg_data  out  8  latched register data
- m_done  in  1  one-cycle pulse from master: transaction finished
- m_nack  in  1  valid with m_done; 1 = slave NACK
- cam_sel  out  1  0 = master routed to CAM1 pins, 1 = CAM2
- busy  out  1  state != IDLE

Behaviour:
- Clock: single clk. Reset is synchronous and active-high.
- Reset values:
  - State IDLE.
  - ack0, ack1, err0, err1, m_start, cam_sel, busy all 0.
  - m_reg_addr and m_reg_data 0.
  - last_grant = 1, so CAM1 wins the first contention.
  - Retry and cycle counters 0.
- Reset asserted mid-operation forces all of the above on the next edge. An m_start in flight is dropped; no ack is issued.
- States: IDLE, SELECT, START, WAIT, GAP.
- IDLE: at each edge, sample req0/req1.
  - Neither asserted: stay in IDLE.
  - One asserted: grant it.
  - Both asserted: grant the requester != last_grant.
  - On grant: latch addr/data into m_reg_addr/m_reg_data, set cam_sel and last_grant to the granted index, clear the retry count, go to SELECT.
- SELECT: hold for exactly SETUP_CYCLES cycles, then go to START.
- START: m_start = 1 for exactly one cycle, then go to WAIT.
- WAIT: cycle counter increments each cycle.
  - m_done with m_nack = 0: success.
  - m_done with m_nack = 1, or counter reaches TIMEOUT_CYCLES: failure.
  - m_done and timeout in the same cycle: m_done wins.
- Success: pulse ack(granted) = 1 with err = 0 for one cycle, then go to GAP.
- Failure with retry_cnt < MAX_RETRY: increment retry_cnt, go to GAP, then to START again. Same grant, no re-arbitration, latched data reused.
- Failure with retry_cnt = MAX_RETRY: pulse ack(granted) with err = 1, then go to GAP.
- err outputs are valid only while the corresponding ack is 1, and are 0 otherwise.
- GAP: hold for exactly GAP_CYCLES cycles, then go to IDLE, or to START if a retry is pending. cam_sel holds its value through GAP and IDLE and changes only on a new grant.
- Latency from req sampled in IDLE at edge N:
  - cam_sel valid at N+1.
  - m_start high in cycle N+1+SETUP_CYCLES.
- Requester rules: drop req, or present a new transaction, in the cycle after ack. Because GAP always follows ack, a held req is never double-granted.
- m_done outside WAIT is ignored.
- Total attempts per grant = 1 + MAX_RETRY.

Test Plan:
- Single request: req0 with addr0 = 8'h12, data0 = 8'h80 → cam_sel = 0; m_start pulses once at N+5 with m_reg_addr = 8'h12, m_reg_data = 8'h80, m_dev_id = 8'h42; m_done (nack = 0) → ack0 one cycle, err0 = 0; busy drops after 100 GAP cycles.
- Contention: req0 and req1 asserted together from reset → CAM1 is served first; the next grant goes to CAM2 (cam_sel = 1) even though req0 is re-asserted; the third grant goes to CAM1.
- NACK retry: master returns nack = 1 twice, then nack = 0 → exactly 3 m_start pulses, each separated by 100-cycle gaps; a single ack1 with err1 = 0.
- Exhausted retries: always nack = 1 → 4 m_start pulses, then ack with err = 1; a pending req on the other port is granted only after the final GAP.
- Timeout: no m_done (TIMEOUT_CYCLES = 20 in the bench) → retry after 20 WAIT cycles; m_done coincident with the 20th cycle counts as success.
- Reset mid-WAIT: reset asserted → next cycle state IDLE, busy = 0, no ack; a held req0 is re-granted and m_start re-issued after SETUP_CYCLES.

Source files
------------

// File: rtl/sccb_cfg_arbiter.sv
// Round-robin arbiter sharing one SCCB write master between two camera
// configuration sequencers, with setup, retry, timeout and gap sequencing.
module sccb_cfg_arbiter #(
   parameter logic [7:0] DEV_ID         = 8'h42,
   parameter int         SETUP_CYCLES   = 4,
   parameter int         GAP_CYCLES     = 100,
   parameter int         MAX_RETRY      = 3,
   parameter int         TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req0,
   input  logic [7:0] addr0,
   input  logic [7:0] data0,
   output logic       ack0,
   output logic       err0,
   input  logic       req1,
   input  logic [7:0] addr1,
   input  logic [7:0] data1,
   output logic       ack1,
   output logic       err1,
   output logic       m_start,
   output logic [7:0] m_dev_id,
   output logic [7:0] m_reg_addr,
   output logic [7:0] m_reg_data,
   input  logic       m_done,
   input  logic       m_nack,
   output logic       cam_sel,
   output logic       busy
);

   localparam int CMAX0 =
      (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
   localparam int CMAX =
      (CMAX0 > SETUP_CYCLES) ? CMAX0 : SETUP_CYCLES;
   localparam int CW = $clog2(CMAX + 1);
   localparam int RW = $clog2(MAX_RETRY + 2);

   localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);
   localparam logic [CW-1:0] TO_LAST    = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);
   localparam logic [CW-1:0] CNT_ONE    = CW'(1);
   localparam logic [RW-1:0] RETRY_ONE  = RW'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SELECT,
      S_START,
      S_WAIT,
      S_GAP
   } state_e;

   state_e        state_q;
   logic [CW-1:0] cnt_q;
   logic [RW-1:0] retry_q;
   logic          retry_pend_q;
   logic          last_q;
   logic          sel_q;
   logic          ack0_q;
   logic          ack1_q;
   logic          err0_q;
   logic          err1_q;
   logic          start_q;
   logic          busy_q;
   logic [7:0]    addr_q;
   logic [7:0]    data_q;

   logic          gnt_vld_d;
   logic          gnt_idx_d;
   logic [7:0]    gnt_addr_d;
   logic [7:0]    gnt_data_d;
   logic          ok_d;
   logic          fail_d;

   // Under contention the requester that was not served last wins.
   always_comb begin
      gnt_vld_d = req0 | req1;
      gnt_idx_d = 1'b0;
      if (req0 && req1) begin
         gnt_idx_d = ~last_q;
      end else begin
         gnt_idx_d = req1;
      end
      gnt_addr_d = gnt_idx_d ? addr1 : addr0;
      gnt_data_d = gnt_idx_d ? data1 : data0;
   end

   // A done pulse takes precedence over a coincident timeout.
   always_comb begin
      ok_d   = m_done & ~m_nack;
      fail_d = (m_done & m_nack) | (~m_done & (cnt_q == TO_LAST));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         retry_q      <= '0;
         retry_pend_q <= 1'b0;
         last_q       <= 1'b1;
         sel_q        <= 1'b0;
         ack0_q       <= 1'b0;
         ack1_q       <= 1'b0;
         err0_q       <= 1'b0;
         err1_q       <= 1'b0;
         start_q      <= 1'b0;
         busy_q       <= 1'b0;
         addr_q       <= '0;
         data_q       <= '0;
      end else begin
         ack0_q  <= 1'b0;
         ack1_q  <= 1'b0;
         err0_q  <= 1'b0;
         err1_q  <= 1'b0;
         start_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (gnt_vld_d) begin
                  state_q      <= S_SELECT;
                  sel_q        <= gnt_idx_d;
                  last_q       <= gnt_idx_d;
                  addr_q       <= gnt_addr_d;
                  data_q       <= gnt_data_d;
                  retry_q      <= '0;
                  retry_pend_q <= 1'b0;
                  cnt_q        <= '0;
                  busy_q       <= 1'b1;
               end
            end
            S_SELECT: begin
               if (cnt_q == SETUP_LAST) begin
                  state_q <= S_START;
                  start_q <= 1'b1;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            S_START: begin
               state_q <= S_WAIT;
               cnt_q   <= '0;
            end
            S_WAIT: begin
               if (ok_d) begin
                  state_q <= S_GAP;
                  cnt_q   <= '0;
                  ack0_q  <= ~sel_q;
                  ack1_q  <= sel_q;
               end else if (fail_d) begin
                  state_q <= S_GAP;
                  cnt_q   <= '0;
                  if (retry_q == RETRY_MAX) begin
                     ack0_q <= ~sel_q;
                     ack1_q <= sel_q;
                     err0_q <= ~sel_q;
                     err1_q <= sel_q;
                  end else begin
                     retry_q      <= retry_q + RETRY_ONE;
                     retry_pend_q <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            S_GAP: begin
               if (cnt_q == GAP_LAST) begin
                  cnt_q <= '0;
                  if (retry_pend_q) begin
                     state_q      <= S_START;
                     start_q      <= 1'b1;
                     retry_pend_q <= 1'b0;
                  end else begin
                     state_q <= S_IDLE;
                     busy_q  <= 1'b0;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign ack0       = ack0_q;
   assign ack1       = ack1_q;
   assign err0       = err0_q;
   assign err1       = err1_q;
   assign m_start    = start_q;
   assign m_dev_id   = DEV_ID;
   assign m_reg_addr = addr_q;
   assign m_reg_data = data_q;
   assign cam_sel    = sel_q;
   assign busy       = busy_q;

endmodule
